// File: rtl/demultiplexador_quatro_pkg.sv
// Shared constants for the 1:4 demultiplexer: channel count, index width
// and the symbolic channel indices A..D.
package demultiplexador_quatro_pkg;

    localparam int NUM_CANAIS     = 4;
    localparam int LARGURA_INDICE = 2;

    localparam logic [LARGURA_INDICE-1:0] CANAL_A = 2'd0;
    localparam logic [LARGURA_INDICE-1:0] CANAL_B = 2'd1;
    localparam logic [LARGURA_INDICE-1:0] CANAL_C = 2'd2;
    localparam logic [LARGURA_INDICE-1:0] CANAL_D = 2'd3;

endpackage

// File: rtl/demultiplexador_quatro_canal_saida.sv
// One-entry output holding register for a single demux channel.
// Load wins over drain, so a channel can take a new word every cycle.
module canal_saida #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               drain,
    input  logic [LARGURA-1:0] dadoNovo,
    output logic [LARGURA-1:0] dado,
    output logic               valido
);

    // Data is kept after a drain; drain is only meaningful while a word is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            dado   <= '0;
            valido <= 1'b0;
        end else if (load) begin
            dado   <= dadoNovo;
            valido <= 1'b1;
        end else if (valido && drain) begin
            valido <= 1'b0;
        end
    end

endmodule

// File: rtl/demultiplexador_quatro.sv
// 1:4 demultiplexer with valid/ready input and one holding register per
// channel; steering is manual (chave1:chave0) or round-robin (ponteiro).
module demultiplexador_quatro
    import demultiplexador_quatro_pkg::*;
#(
    parameter int LARGURA = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LARGURA-1:0]        inX,
    input  logic                      inValido,
    output logic                      inPronto,
    input  logic                      chave0,
    input  logic                      chave1,
    input  logic                      modoAuto,
    output logic [LARGURA-1:0]        outA,
    output logic [LARGURA-1:0]        outB,
    output logic [LARGURA-1:0]        outC,
    output logic [LARGURA-1:0]        outD,
    output logic [NUM_CANAIS-1:0]     outValido,
    input  logic [NUM_CANAIS-1:0]     outPronto,
    output logic [LARGURA_INDICE-1:0] ponteiro
);

    logic [LARGURA_INDICE-1:0] alvo;
    logic                      aceite;
    logic [LARGURA-1:0]        dados [NUM_CANAIS];

    // No skipping: a busy target stalls input even if other channels are free.
    assign alvo     = modoAuto ? ponteiro : {chave1, chave0};
    assign inPronto = !outValido[alvo] | outPronto[alvo];
    assign aceite   = inValido & inPronto;

    for (genvar i = 0; i < NUM_CANAIS; i++) begin : gCanal
        canal_saida #(
            .LARGURA (LARGURA)
        ) uCanal (
            .clock    (clock),
            .reset    (reset),
            .load     (aceite && (alvo == LARGURA_INDICE'(i))),
            .drain    (outPronto[i]),
            .dadoNovo (inX),
            .dado     (dados[i]),
            .valido   (outValido[i])
        );
    end

    assign outA = dados[CANAL_A];
    assign outB = dados[CANAL_B];
    assign outC = dados[CANAL_C];
    assign outD = dados[CANAL_D];

    // Pointer advances only on auto-mode accepts and wraps naturally at 2 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            ponteiro <= CANAL_A;
        end else if (aceite && modoAuto) begin
            ponteiro <= ponteiro + 1'b1;
        end
    end

endmodule
